// File: rtl/sar_search.sv
// -----------------------------------------------------------------------------
// sar_search
//
// Successive-approximation search controller. Drives a trial value into an
// external magnitude comparator (trial vs. unknown target), consumes its
// greater/less/equal outputs and resolves the target MSB-first, one bit per
// clock edge, in WIDTH decision cycles.
//
// Parameters:
//   WIDTH   bit width of trial/result; must match the comparator width
//
// Ports:
//   clk     in   system clock, rising-edge active
//   rst     in   asynchronous, active-high reset
//   start   in   begin a search; sampled only while idle
//   gti     in   comparator: trial > target
//   lti     in   comparator: trial < target
//   eqi     in   comparator: trial == target
//   trial   out  value driven to the comparator's first operand
//   result  out  resolved target; valid with done, held until next start
//   busy    out  high while searching
//   done    out  one-cycle pulse when result/err are updated
//   err     out  invalid comparator code seen during the last search
//
// Build option:
//   SAR_SEARCH_EARLY_EXIT_EN  when defined, an eqi decision ends the search
//                             immediately with the current trial as result.
//                             When undefined, eqi keeps the bit like lti and
//                             every search runs all WIDTH decisions.
// -----------------------------------------------------------------------------
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gti,
    input  logic             lti,
    input  logic             eqi,
    output logic [WIDTH-1:0] trial,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t            state_q,  state_d;
    logic [IDXW-1:0]   idx_q,    idx_d;
    logic [WIDTH-1:0]  trial_q,  trial_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;

    logic              code_valid;
    logic              eq_exit;
    logic              last_decision;
    logic [IDXW-1:0]   idx_m1;
    logic [WIDTH-1:0]  decided;
    logic [WIDTH-1:0]  next_trial;

    // Exactly one comparator flag must be high for a usable decision.
    assign code_valid = ( gti & ~lti & ~eqi) |
                        (~gti &  lti & ~eqi) |
                        (~gti & ~lti &  eqi);

`ifdef SAR_SEARCH_EARLY_EXIT_EN
    assign eq_exit = code_valid & eqi;
`else
    assign eq_exit = 1'b0;
`endif

    assign last_decision = (idx_q == '0);
    assign idx_m1        = idx_q - IDXW'(1);

    // Bit idx is always set in the current trial, so the decision only has
    // to clear it on gti; lti and eqi leave it as is.
    always_comb begin
        decided = trial_q;
        decided[idx_q] = ~gti;
        next_trial = decided;
        if (!last_decision) begin
            next_trial[idx_m1] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                // Also reached in the done cycle, so back-to-back starts work.
                if (start) begin
                    state_d        = SEARCH;
                    trial_d        = '0;
                    trial_d[WIDTH-1] = 1'b1;
                    idx_d          = IDXW'(WIDTH - 1);
                    busy_d         = 1'b1;
                    err_d          = 1'b0;
                end
            end

            SEARCH: begin
                if (!code_valid) begin
                    // Abort with whatever trial was under test at this edge.
                    result_d = trial_q;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (eq_exit) begin
                    result_d = trial_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (last_decision) begin
                    trial_d  = decided;
                    result_d = decided;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    trial_d  = next_trial;
                    idx_d    = idx_m1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign trial  = trial_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// -----------------------------------------------------------------------------
// tb_sar_search
//
// Directed bench for sar_search (WIDTH=4). A behavioural comparator compares
// trial against tgt; force_bad overrides it with the invalid code gt=lt=1.
// Expected values follow the SAR_SEARCH_EARLY_EXIT_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       force_bad = 1'b0;
    logic [3:0] tgt = 4'h0;
    logic       gti, lti, eqi;
    logic [3:0] trial, result;
    logic       busy, done, err;

    int checks   = 0;
    int failures = 0;

    logic [3:0] trs [0:7];
    int         ntr;
    int         edges;

    always #5 clk = ~clk;

    assign gti = force_bad ? 1'b1 : (trial >  tgt);
    assign lti = force_bad ? 1'b1 : (trial <  tgt);
    assign eqi = force_bad ? 1'b0 : (trial == tgt);

    sar_search #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .gti   (gti),
        .lti   (lti),
        .eqi   (eqi),
        .trial (trial),
        .result(result),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

`ifdef SAR_SEARCH_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    // Pulse start for one edge, record trials while busy and count edges
    // from the start edge up to the first cycle with done high (bounded).
    task automatic do_search(input logic [3:0] t);
        @(negedge clk);
        tgt   = t;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        ntr   = 0;
        while (!done && edges < 20) begin
            if (busy && ntr < 8) begin
                trs[ntr] = trial;
                ntr++;
            end
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({trial, result, busy, done, err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state: got trial=%b result=%b busy=%b done=%b err=%b, want all 0",
                     trial, result, busy, done, err);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_search_targets();
        logic [3:0]  v_tgt   [0:2];
        logic [15:0] v_tr    [0:2];
        int          v_n     [0:2];
        int          v_edges [0:2];
        logic [3:0]  exp_t;
        v_tgt[0] = 4'b0110; v_tr[0] = 16'h8467;
        v_tgt[1] = 4'b0000; v_tr[1] = 16'h8421;
        v_tgt[2] = 4'b1111; v_tr[2] = 16'h8CEF;
        v_n[0] = EE ? 3 : 4; v_edges[0] = EE ? 4 : 5;
        v_n[1] = 4;          v_edges[1] = 5;
        v_n[2] = 4;          v_edges[2] = 5;
        for (int v = 0; v < 3; v++) begin
            do_search(v_tgt[v]);
            checks++;
            if (edges !== v_edges[v]) begin
                failures++;
                $display("FAIL latency t=%b: got %0d edges, want %0d", v_tgt[v], edges, v_edges[v]);
            end
            checks++;
            if (ntr !== v_n[v]) begin
                failures++;
                $display("FAIL trial_count t=%b: got %0d, want %0d", v_tgt[v], ntr, v_n[v]);
            end
            for (int i = 0; i < v_n[v] && i < ntr; i++) begin
                exp_t = v_tr[v][15-4*i -: 4];
                checks++;
                if (trs[i] !== exp_t) begin
                    failures++;
                    $display("FAIL trial_seq t=%b step %0d: got %b, want %b", v_tgt[v], i, trs[i], exp_t);
                end
            end
            checks++;
            if ({result, err, busy, done, trial} !== {v_tgt[v], 1'b0, 1'b0, 1'b1, v_tgt[v]}) begin
                failures++;
                $display("FAIL done_cycle t=%b: got result=%b err=%b busy=%b done=%b trial=%b, want result=%b err=0 busy=0 done=1 trial=%b",
                         v_tgt[v], result, err, busy, done, trial, v_tgt[v], v_tgt[v]);
            end
            @(posedge clk); #1;
            checks++;
            if ({done, result} !== {1'b0, v_tgt[v]}) begin
                failures++;
                $display("FAIL done_pulse t=%b: got done=%b result=%b, want done=0 result=%b",
                         v_tgt[v], done, result, v_tgt[v]);
            end
        end
    endtask

    task automatic test_invalid_code();
        @(negedge clk);
        tgt   = 4'b1010;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (trial !== 4'b1100) begin
            failures++;
            $display("FAIL invalid_pre: got trial=%b, want 1100", trial);
        end
        force_bad = 1'b1;
        @(posedge clk); #1;
        force_bad = 1'b0;
        checks++;
        if ({done, err, busy, result} !== {1'b1, 1'b1, 1'b0, 4'b1100}) begin
            failures++;
            $display("FAIL invalid_code: got done=%b err=%b busy=%b result=%b, want 1 1 0 1100",
                     done, err, busy, result);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, err, busy, result} !== {1'b0, 1'b1, 1'b0, 4'b1100}) begin
            failures++;
            $display("FAIL invalid_hold: got done=%b err=%b busy=%b result=%b, want 0 1 0 1100",
                     done, err, busy, result);
        end
    endtask

    task automatic test_reset_mid_search();
        int ndone;
        @(negedge clk);
        tgt   = 4'b0110;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({trial, result, busy, done, err} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset: got trial=%b result=%b busy=%b done=%b err=%b, want all 0",
                     trial, result, busy, done, err);
        end
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL abandoned_search: got %0d cycles with done/busy, want 0", ndone);
        end
        do_search(4'b1010);
        checks++;
        if ({result, err, done, edges} !== {4'b1010, 1'b0, 1'b1, (EE ? 32'd4 : 32'd5)}) begin
            failures++;
            $display("FAIL after_reset_search: got result=%b err=%b done=%b edges=%0d, want 1010 0 1 %0d",
                     result, err, done, edges, EE ? 4 : 5);
        end
    endtask

    task automatic test_start_while_busy();
        @(negedge clk);
        tgt   = 4'b0110;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 3;
        while (!done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if ({result, err, edges} !== {4'b0110, 1'b0, (EE ? 32'd4 : 32'd5)}) begin
            failures++;
            $display("FAIL start_while_busy: got result=%b err=%b edges=%0d, want 0110 0 %0d",
                     result, err, edges, EE ? 4 : 5);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        tgt   = 4'b0000;
        start = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        while (!done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if ({result, done, edges} !== {4'b0000, 1'b1, 32'd5}) begin
            failures++;
            $display("FAIL b2b_first: got result=%b done=%b edges=%0d, want 0000 1 5", result, done, edges);
        end
        tgt = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({done, busy, trial} !== {1'b0, 1'b1, 4'b1000}) begin
            failures++;
            $display("FAIL b2b_restart: got done=%b busy=%b trial=%b, want 0 1 1000", done, busy, trial);
        end
        edges = 1;
        while (!done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if ({result, err, edges} !== {4'b1111, 1'b0, 32'd5}) begin
            failures++;
            $display("FAIL b2b_second: got result=%b err=%b edges=%0d, want 1111 0 5", result, err, edges);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_search_targets();
        test_invalid_code();
        test_reset_mid_search();
        test_start_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search controller; the driving end of the magnitude-comparator interface.
- Presents trial values to an external comparator (trial vs. unknown target) and consumes its greater/less/equal outputs.
- Resolves the target MSB-first in WIDTH decision cycles.
- Sits beside comparator_4b in the datapath library; used for threshold search and ADC-style conversion.

Parameters:
WIDTH, 4, bit width of trial/result; must match the comparator width (4 for comparator_4b).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  begin a search; sampled only in IDLE
gti  input  1  comparator: trial > target
lti  input  1  comparator: trial < target
eqi  input  1  comparator: trial == target
trial  output  WIDTH  value driven to the comparator's first operand
result  output  WIDTH  resolved target; valid while done high, held until next start
busy  output  1  high while searching
done  output  1  one-cycle pulse when result/err are updated
err  output  1  invalid comparator code seen during the last search; held until next start

Behaviour:
- Reset (asynchronous, active-high, any time including mid-search): state=IDLE; trial, result, busy, done, err all 0. Search is abandoned with no done pulse.
- States: IDLE, SEARCH. idx is a log2(WIDTH)-bit bit pointer.
- IDLE:
  - start=1 at an edge -> SEARCH; trial<=1<<(WIDTH-1); idx<=WIDTH-1; busy<=1; err<=0.
  - done is low in all IDLE cycles except the one following a completed search.
- SEARCH: comparator is combinational from trial; one decision per edge, using the {gti,lti,eqi} code sampled at that edge.
  - lti or eqi: keep bit idx.
  - gti: clear bit idx.
  - idx>0: also set bit idx-1; idx<=idx-1.
  - idx==0: result<=decided trial; done<=1; busy<=0; -> IDLE. trial holds the final value.
- Code validity: exactly one of gti/lti/eqi must be high. Any other code (none, or more than one) -> result<=trial; err<=1; done<=1; busy<=0; -> IDLE.
- Latency: start sampled at edge E0; decisions at E1..E_WIDTH; done high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after start.
- start while busy: ignored.
- start during the done cycle: accepted (back-to-back searches); done still deasserts next cycle.
- Arithmetic: unsigned. Results for targets 0 and 2^WIDTH-1 are exact; no wrap-around is possible.

Optional Feature:
- Macro: SAR_SEARCH_EARLY_EXIT_EN.
- Defined: eqi=1 on any SEARCH edge terminates immediately: result<=trial; done<=1; -> IDLE. Latency becomes the number of edges up to the first eqi, plus the done cycle.
- Undefined: eqi is treated like lti (bit kept) and the search always runs all WIDTH decisions.
- Final result is identical in both builds for valid comparator behaviour.

Test Plan (WIDTH=4, trial wired to comparator_4b num1, target to num2):
- target=0110, start -> trial sequence 1000,0100,0110,0111; result=0110, done 5 edges after start, err=0. With SAR_SEARCH_EARLY_EXIT_EN: sequence 1000,0100,0110; done 4 edges after start.
- target=0000 -> trials 1000,0100,0010,0001 all gt; result=0000.
- target=1111 -> trials 1000,1100,1110,1111; result=1111. With SAR_SEARCH_EARLY_EXIT_EN: eq exit at the 4th trial; same latency.
- Comparator stub forces gti=lti=1 on the 2nd decision -> err=1, done pulse, result=1100 (trial at that edge), busy=0.
- rst asserted mid-search after 2 decisions (asynchronously, between edges) -> all outputs 0 immediately, no done pulse. A new start then completes normally (target=1010 -> 1010).
- start re-pulsed while busy -> ignored, first search result unchanged. start held during the done cycle -> second search begins with trial=1000 on the next cycle.
